// File: rtl/pulse_burst_gen_if.sv
// Control/status bundle for pulse_burst_gen: slow-rate reference, burst
// requests and programming in; strobes, burst output and status out.
interface pulse_burst_gen_if;
  logic        div_clk;
  logic        trig;
  logic        abort;
  logic [15:0] n_pulses;
  logic [15:0] width;
  logic        tick;
  logic        pulse_out;
  logic        busy;
  logic        done;
  logic        overrun;
  logic [15:0] pulse_count;

  modport master (
    output div_clk, trig, abort, n_pulses, width,
    input  tick, pulse_out, busy, done, overrun, pulse_count
  );

  modport slave (
    input  div_clk, trig, abort, n_pulses, width,
    output tick, pulse_out, busy, done, overrun, pulse_count
  );
endinterface

// File: rtl/pulse_burst_gen.sv
// Burst pulse generator phase-locked to rising edges of a divided clock that
// already lives in the clk domain; each pulse starts on a div_clk edge.
module pulse_burst_gen (
  input  logic              clk,
  input  logic              rst,
  pulse_burst_gen_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ARMED, HIGH} state_t;

  state_t      state, state_nxt;
  logic        div_q;
  logic        e;
  logic [15:0] n_s, w_s;
  logic [15:0] wcnt;
  logic [15:0] pcnt;
  logic        tick_r, done_r, ovr_r;
  logic [15:0] width_clamped;
  logic        latch, start_pulse, finish, hold_high;

  assign e             = bus.div_clk & ~div_q;
  assign width_clamped = (bus.width == 16'd0) ? 16'd1 : bus.width;

  always_comb begin
    state_nxt   = state;
    latch       = 1'b0;
    start_pulse = 1'b0;
    finish      = 1'b0;
    hold_high   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.trig) begin
          state_nxt = ARMED;
          latch     = 1'b1;
        end
      end
      ARMED: begin
        if (e) begin
          state_nxt   = HIGH;
          start_pulse = 1'b1;
        end
      end
      HIGH: begin
        // Edges seen here are dropped; the next pulse needs a fresh edge in ARMED.
        if (wcnt == 16'd0) begin
          if ((n_s != 16'd0) && (pcnt == n_s)) begin
            state_nxt = IDLE;
            finish    = 1'b1;
          end else begin
            state_nxt = ARMED;
          end
        end else begin
          hold_high = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.abort) begin
      state_nxt   = IDLE;
      latch       = 1'b0;
      start_pulse = 1'b0;
      finish      = 1'b0;
      hold_high   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= 1'b1;
      tick_r <= 1'b0;
      done_r <= 1'b0;
      ovr_r  <= 1'b0;
      pcnt   <= 16'd0;
      wcnt   <= 16'd0;
      n_s    <= 16'd0;
      w_s    <= 16'd1;
    end else begin
      div_q  <= bus.div_clk;
      tick_r <= e;
      done_r <= finish;
      if (latch) begin
        n_s   <= bus.n_pulses;
        w_s   <= width_clamped;
        pcnt  <= 16'd0;
        ovr_r <= 1'b0;
      end
      if (start_pulse) begin
        wcnt <= w_s - 16'd1;
        pcnt <= pcnt + 16'd1;
      end else if (hold_high) begin
        wcnt <= wcnt - 16'd1;
      end
      if ((state == HIGH) && e && !bus.abort) ovr_r <= 1'b1;
    end
  end

  assign bus.tick        = tick_r;
  assign bus.pulse_out   = (state == HIGH);
  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_r;
  assign bus.overrun     = ovr_r;
  assign bus.pulse_count = pcnt;

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Randomized + directed bench: a time-based burst model predicts every output
// cycle; a negedge monitor pops predictions from a queue and compares.
module tb_pulse_burst_gen;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  pulse_burst_gen_if bus();

  pulse_burst_gen dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        tick;
    logic        pulse_out;
    logic        busy;
    logic        done;
    logic        overrun;
    logic [15:0] pcnt;
  } exp_t;

  exp_t q[$];

  // Reference model: bursts described by absolute cycle numbers.
  logic        m_prev, m_tick, m_busy, m_puls, m_ovr, m_done;
  int          m_last, m_w;
  logic [15:0] m_n, m_cnt;

  // div_clk source
  logic div_lvl, div_hold;
  int   half, dcnt;

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp, input int c);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, c, got, exp);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t x;
      x = q.pop_front();
      chk("tick",        {15'd0, bus.tick},      {15'd0, x.tick},      x.cyc);
      chk("pulse_out",   {15'd0, bus.pulse_out}, {15'd0, x.pulse_out}, x.cyc);
      chk("busy",        {15'd0, bus.busy},      {15'd0, x.busy},      x.cyc);
      chk("done",        {15'd0, bus.done},      {15'd0, x.done},      x.cyc);
      chk("overrun",     {15'd0, bus.overrun},   {15'd0, x.overrun},   x.cyc);
      chk("pulse_count", bus.pulse_count,        x.pcnt,               x.cyc);
    end
  end

  // Predict outputs after posedge k from the inputs currently applied.
  task automatic model_step(input int k);
    logic e;
    exp_t x;
    e = bus.div_clk & ~m_prev;
    if (rst) begin
      m_prev = 1'b1; m_tick = 1'b0; m_busy = 1'b0; m_puls = 1'b0;
      m_cnt = 16'd0; m_ovr = 1'b0; m_done = 1'b0;
    end else begin
      m_prev = bus.div_clk;
      m_tick = e;
      m_done = 1'b0;
      if (bus.abort) begin
        m_busy = 1'b0; m_puls = 1'b0;
      end else if (!m_busy) begin
        if (bus.trig) begin
          m_busy = 1'b1; m_puls = 1'b0;
          m_n = bus.n_pulses;
          m_w = (bus.width == 16'd0) ? 1 : int'(bus.width);
          m_cnt = 16'd0; m_ovr = 1'b0;
        end
      end else if (!m_puls) begin
        if (e) begin
          m_puls = 1'b1;
          m_last = k + m_w - 1;
          m_cnt  = m_cnt + 16'd1;
        end
      end else begin
        if (e) m_ovr = 1'b1;
        if (k - 1 == m_last) begin
          m_puls = 1'b0;
          if (m_n != 16'd0 && m_cnt == m_n) begin
            m_busy = 1'b0; m_done = 1'b1;
          end
        end
      end
    end
    x.cyc = k; x.tick = m_tick; x.pulse_out = m_busy & m_puls; x.busy = m_busy;
    x.done = m_done; x.overrun = m_ovr; x.pcnt = m_cnt;
    q.push_back(x);
  endtask

  task automatic cycle();
    if (!div_hold) begin
      dcnt++;
      if (dcnt >= half) begin
        dcnt = 0;
        div_lvl = ~div_lvl;
      end
    end
    bus.div_clk = div_lvl;
    model_step(cyc + 1);
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic trig_pulse(input logic [15:0] n, input logic [15:0] w);
    bus.n_pulses = n; bus.width = w; bus.trig = 1'b1;
    cycle();
    bus.trig = 1'b0;
  endtask

  task automatic wait_mid_pulse();
    for (int i = 0; i < 40 && !(m_busy && m_puls); i++) cycle();
  endtask

  initial begin
    m_prev = 1'b1; m_tick = 1'b0; m_busy = 1'b0; m_puls = 1'b0; m_ovr = 1'b0;
    m_done = 1'b0; m_cnt = 16'd0; m_n = 16'd0; m_w = 1; m_last = 0;
    div_lvl = 1'b1; div_hold = 1'b1; half = 5; dcnt = 0;
    rst = 1'b1; bus.div_clk = 1'b1; bus.trig = 1'b0; bus.abort = 1'b0;
    bus.n_pulses = 16'd0; bus.width = 16'd0;

    // div_clk high through reset release: no tick until a real edge
    run(3); rst = 1'b0; run(4);
    div_hold = 1'b0; run(40);

    trig_pulse(16'd3, 16'd4);  run(80);   // finite burst
    trig_pulse(16'd2, 16'd0);  run(50);   // width 0 -> 1
    trig_pulse(16'd2, 16'd10); run(80);   // overrun, every other period

    trig_pulse(16'd0, 16'd2); run(60);    // continuous, then abort mid-pulse
    wait_mid_pulse();
    bus.abort = 1'b1; cycle(); bus.abort = 1'b0; run(20);

    // trig held through bursts, inputs changed mid-burst
    bus.n_pulses = 16'd2; bus.width = 16'd3; bus.trig = 1'b1; run(30);
    bus.n_pulses = 16'd5; bus.width = 16'd7; run(70);
    bus.trig = 1'b0; run(30);

    trig_pulse(16'd0, 16'd6); run(15);    // reset mid-pulse, then clean burst
    wait_mid_pulse();
    rst = 1'b1; cycle(); rst = 1'b0; run(5);
    trig_pulse(16'd2, 16'd3); run(60);

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 199) == 0) half = $urandom_range(1, 8);
      if ($urandom_range(0, 31) == 0) begin
        bus.n_pulses = 16'($urandom_range(0, 4));
        bus.width    = 16'($urandom_range(0, 12));
      end
      bus.trig  = ($urandom_range(0, 15) == 0);
      bus.abort = ($urandom_range(0, 99) == 0);
      rst       = ($urandom_range(0, 499) == 0);
      cycle();
    end
    bus.trig = 1'b0; bus.abort = 1'b0; rst = 1'b0;
    run(5);

    @(negedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got=%0d exp=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
